// File: rtl/rfsoc_config.sv
// Shared RFSoC PL configuration: capture FSM state encoding and default
// datapath widths used by the ADC capture blocks.
package rfsoc_config;

    typedef enum logic [2:0] {
        CAP_IDLE    = 3'd0,
        CAP_ARMED   = 3'd1,
        CAP_DELAY   = 3'd2,
        CAP_CAPTURE = 3'd3,
        CAP_READY   = 3'd4,
        CAP_READOUT = 3'd5
    } adc_cap_state_t;

    // Beat width of the RFSoC ADC tile stream and the readout bus.
    localparam int adc_axis_width = 128;

    // Default capture depth: 2^10 beats.
    localparam int adc_cap_addr_w = 10;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port
// (1-cycle read latency). Maps onto block RAM.
module capture_ram
    import rfsoc_config::*;
#(
    parameter int ADDR_W = adc_cap_addr_w,
    parameter int DATA_W = adc_axis_width
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // Write port and registered read port share the single clock.
    // NOTE: the array and its read register have no reset so the tools can
    // map them onto block RAM; nothing downstream trusts the contents until
    // they have been written. Sequential state uses <= so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC capture buffer for one RFSoC ADC channel (pl_clk domain).
// Armed capture waits for a trigger rising edge plus a programmable delay,
// stores a fixed-length window into capture_ram and replays it on a
// 128-bit AXIS master when the channel is selected.
// Build option: define ADC_CAPTURE_TLAST_EN to add m_axis_tlast on the
// final readout beat.
module adc_capture_ctrl
    import rfsoc_config::*;
#(
    parameter int ADDR_W = adc_cap_addr_w,
    parameter int DATA_W = adc_axis_width
) (
    input  logic              pl_clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic [15:0]       capture_delay,
    input  logic [ADDR_W:0]   capture_len,
    input  logic              channel_sel,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
`ifdef ADC_CAPTURE_TLAST_EN
    output logic              m_axis_tlast,
`endif
    output logic              busy,
    output logic              done,
    output logic              trig_missed
);

    localparam logic [2:0] S_IDLE    = 3'(CAP_IDLE);
    localparam logic [2:0] S_ARMED   = 3'(CAP_ARMED);
    localparam logic [2:0] S_DELAY   = 3'(CAP_DELAY);
    localparam logic [2:0] S_CAPTURE = 3'(CAP_CAPTURE);
    localparam logic [2:0] S_READY   = 3'(CAP_READY);
    localparam logic [2:0] S_READOUT = 3'(CAP_READOUT);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic              trigger_q;
    logic              trig_edge;
    logic              arm_ok;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_last;
    logic [15:0]       delay_q;
    logic [15:0]       delay_cnt;

    logic [ADDR_W:0]   wr_cnt;
    logic              wr_en;

    logic [ADDR_W:0]   rd_ptr;
    logic              rd_issue;
    logic              rd_pend;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W:0]   out_cnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              out_fire;
    logic              out_load;
    logic              skid_to_out;
    logic              ram_to_out;
    logic              ram_to_skid;
    logic              skid_valid_nx;
    logic              out_valid_nx;

    assign trig_edge   = trigger & ~trigger_q;
    assign arm_ok      = arm & ((state == S_IDLE) | (state == S_READY));
    assign len_clamped = (capture_len > LEN_MAX) ? LEN_MAX : capture_len;
    assign len_last    = len_q - LEN_ONE;

    assign wr_en = (state == S_CAPTURE) & s_axis_tvalid & (wr_cnt < len_q);

    // Readout pipeline: RAM read -> (skid) -> output register. The skid slot
    // absorbs the read already in flight when the consumer stalls, so the
    // output beat stays put and nothing is dropped.
    assign out_fire      = out_valid & m_axis_tready;
    assign out_load      = ~out_valid | out_fire;
    assign skid_to_out   = out_load & skid_valid;
    assign ram_to_out    = out_load & ~skid_valid & rd_pend;
    assign ram_to_skid   = rd_pend & ~ram_to_out;
    assign skid_valid_nx = ram_to_skid | (skid_valid & ~out_load);
    assign out_valid_nx  = skid_to_out | ram_to_out | (out_valid & ~out_fire);
    assign rd_issue      = (state == S_READOUT) & ~abort & (rd_ptr < len_q) & ~skid_valid_nx;

    // Next-state decode; abort overrides every other event.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned
        // (which would infer a latch).
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm) state_nx = S_ARMED;
                S_ARMED:   if (trig_edge) state_nx = (delay_q == 16'd0) ? S_CAPTURE : S_DELAY;
                S_DELAY:   if (delay_cnt == 16'd0) state_nx = S_CAPTURE;
                S_CAPTURE: if ((len_q == '0) || (wr_en && (wr_cnt == len_last))) state_nx = S_READY;
                S_READY: begin
                    if (arm)              state_nx = S_ARMED;
                    else if (channel_sel) state_nx = S_READOUT;
                end
                S_READOUT: if ((len_q == '0) || (out_fire && (out_cnt == len_last))) state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // State register, trigger edge stage, per-capture configuration and
    // the sticky missed-trigger flag.
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            trigger_q   <= 1'b0;
            len_q       <= '0;
            delay_q     <= '0;
            delay_cnt   <= '0;
            trig_missed <= 1'b0;
        end else begin
            state     <= state_nx;
            trigger_q <= trigger;
            if (abort) begin
                delay_cnt   <= '0;
                trig_missed <= 1'b0;
            end else begin
                if (arm_ok) begin
                    len_q       <= len_clamped;
                    delay_q     <= capture_delay;
                    trig_missed <= 1'b0;
                end else if (trig_edge && ((state == S_DELAY) || (state == S_CAPTURE))) begin
                    trig_missed <= 1'b1;
                end
                if ((state == S_ARMED) && trig_edge) begin
                    delay_cnt <= delay_q - 16'd1;
                end else if (state == S_DELAY) begin
                    delay_cnt <= delay_cnt - 16'd1;
                end
            end
        end
    end

    // Write/read address counters; rearming or aborting restarts them at 0.
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            out_cnt <= '0;
        end else if (abort || arm_ok) begin
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            out_cnt <= '0;
        end else begin
            if (wr_en)    wr_cnt  <= wr_cnt + LEN_ONE;
            if (rd_issue) rd_ptr  <= rd_ptr + LEN_ONE;
            if (out_fire) out_cnt <= out_cnt + LEN_ONE;
        end
    end

    // Readout pipeline valids and the output data register.
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (abort) begin
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            rd_pend    <= rd_issue;
            skid_valid <= skid_valid_nx;
            out_valid  <= out_valid_nx;
            if (skid_to_out) begin
                out_data <= skid_data;
            end else if (ram_to_out) begin
                out_data <= ram_rdata;
            end
        end
    end

    // Skid data slot; only meaningful while skid_valid is set.
    always_ff @(posedge pl_clk) begin
        if (ram_to_skid) begin
            skid_data <= ram_rdata;
        end
    end

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (pl_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    // The ADC is never back-pressured; beats outside CAPTURE are dropped.
    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
`ifdef ADC_CAPTURE_TLAST_EN
    assign m_axis_tlast  = out_valid & (out_cnt == len_last);
`endif
    assign busy = (state == S_ARMED) | (state == S_DELAY) | (state == S_CAPTURE) | (state == S_READOUT);
    assign done = (state == S_READY);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed testbench for adc_capture_ctrl. Inputs change and outputs are
// sampled on the falling edge of pl_clk.
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 128;

    logic              pl_clk;
    logic              rst;
    logic              arm;
    logic              abort;
    logic              trigger;
    logic [15:0]       capture_delay;
    logic [ADDR_W:0]   capture_len;
    logic              channel_sel;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
`ifdef ADC_CAPTURE_TLAST_EN
    logic              m_axis_tlast;
`endif
    logic              busy;
    logic              done;
    logic              trig_missed;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] got     [0:2047];
    int                got_cyc [0:2047];
    int                got_n;

    adc_capture_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .pl_clk        (pl_clk),
        .rst           (rst),
        .arm           (arm),
        .abort         (abort),
        .trigger       (trigger),
        .capture_delay (capture_delay),
        .capture_len   (capture_len),
        .channel_sel   (channel_sel),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef ADC_CAPTURE_TLAST_EN
        .m_axis_tlast  (m_axis_tlast),
`endif
        .busy          (busy),
        .done          (done),
        .trig_missed   (trig_missed)
    );

    initial pl_clk = 1'b0;
    always #5 pl_clk = ~pl_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge pl_clk);
    endtask

    task automatic arm_cfg(input logic [15:0] d, input logic [ADDR_W:0] l);
        capture_delay = d;
        capture_len   = l;
        arm           = 1'b1;
        tick();
        arm           = 1'b0;
    endtask

    // Low for one cycle, then high: the rising edge lands in the second cycle.
    task automatic fire_trigger();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
    endtask

    task automatic feed(input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DATA_W'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic start_readout();
        m_axis_tready = 1'b1;
        channel_sel   = 1'b1;
        tick();
        channel_sel   = 1'b0;
    endtask

    // Records accepted beats (tready held high) with the cycle index relative
    // to the call; stops after max_beats or budget cycles.
    task automatic collect(input int budget, input int max_beats);
        got_n = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (m_axis_tvalid) begin
                got[got_n]     = m_axis_tdata;
                got_cyc[got_n] = c;
                got_n++;
            end
            tick();
            if (got_n >= max_beats) break;
        end
    endtask

    task automatic test_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL reset_tdata: got %0h want 0", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (trig_missed !== 1'b0) begin failures++; $display("FAIL reset_trig_missed: got %0b want 0", trig_missed); end
        checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready: got %0b want 1", s_axis_tready); end
    endtask

    task automatic test_basic_capture();
        arm_cfg(16'd0, 11'd8);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_armed: got %0b want 1", busy); end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 128'hDEAD;
        fire_trigger();
        feed(128'h1, 8);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_ready: got %0b want 0", busy); end
        start_readout();
        collect(30, 8);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL basic_beat_count: got %0d want 8", got_n); end
        checks++; if (got_cyc[0] !== 2) begin failures++; $display("FAIL basic_first_latency: got %0d want 2", got_cyc[0]); end
        checks++; if (got_cyc[7] !== 9) begin failures++; $display("FAIL basic_last_cycle: got %0d want 9", got_cyc[7]); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== 128'h1 + DATA_W'(k)) begin
                failures++; $display("FAIL basic_beat%0d: got %0h want %0h", k, got[k], 128'h1 + DATA_W'(k));
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_after: got %0b want 0", done); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL basic_tvalid_after: got %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_delay();
        logic [DATA_W-1:0] adc;
        logic [DATA_W-1:0] c_edge;
        adc = 128'h100;
        trigger = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = adc; adc = adc + 1;
        tick();
        // Trigger rises on the arm cycle and then stays high: no accepted edge.
        capture_delay = 16'd5;
        capture_len   = 11'd4;
        arm = 1'b1; trigger = 1'b1;
        s_axis_tdata = adc; adc = adc + 1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 12; i++) begin s_axis_tdata = adc; adc = adc + 1; tick(); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL delay_still_armed_busy: got %0b want 1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL delay_arm_edge_ignored: got %0b want 0", done); end
        trigger = 1'b0;
        s_axis_tdata = adc; adc = adc + 1;
        tick();
        trigger = 1'b1;
        c_edge = adc;
        for (int i = 0; i < 12; i++) begin s_axis_tdata = adc; adc = adc + 1; tick(); end
        s_axis_tvalid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL delay_done: got %0b want 1", done); end
        start_readout();
        collect(20, 4);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL delay_beat_count: got %0d want 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== c_edge + DATA_W'(6 + k)) begin
                failures++; $display("FAIL delay_beat%0d: got %0h want %0h", k, got[k], c_edge + DATA_W'(6 + k));
            end
        end
    endtask

    task automatic test_tvalid_gaps();
        arm_cfg(16'd0, 11'd4);
        fire_trigger();
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = (i % 2 == 0);
            s_axis_tdata  = (i % 2 == 0) ? 128'hA0 + DATA_W'(i / 2) : 128'hEE;
            tick();
            if (i == 5) begin
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL gaps_done_early: got %0b want 0", done); end
            end
        end
        s_axis_tvalid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %0b want 1", done); end
        start_readout();
        collect(20, 4);
        checks++; if (got_n !== 4) begin failures++; $display("FAIL gaps_beat_count: got %0d want 4", got_n); end
        checks++; if (got_cyc[3] - got_cyc[0] !== 3) begin failures++; $display("FAIL gaps_readout_span: got %0d want 3", got_cyc[3] - got_cyc[0]); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 128'hA0 + DATA_W'(k)) begin
                failures++; $display("FAIL gaps_beat%0d: got %0h want %0h", k, got[k], 128'hA0 + DATA_W'(k));
            end
        end
    endtask

    task automatic test_stall();
        int n;
        int stalls;
        arm_cfg(16'd0, 11'd8);
        fire_trigger();
        feed(128'h11, 8);
        start_readout();
        n = 0;
        stalls = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (n == 1 && m_axis_tvalid && stalls < 3) begin
                m_axis_tready = 1'b0;
                checks++;
                if (m_axis_tdata !== 128'h12) begin failures++; $display("FAIL stall_hold%0d: got %0h want 12", stalls, m_axis_tdata); end
                stalls++;
            end else begin
                m_axis_tready = 1'b1;
                if (m_axis_tvalid) begin
                    checks++;
                    if (m_axis_tdata !== 128'h11 + DATA_W'(n)) begin
                        failures++; $display("FAIL stall_beat%0d: got %0h want %0h", n, m_axis_tdata, 128'h11 + DATA_W'(n));
                    end
                    n++;
                end
            end
            tick();
        end
        m_axis_tready = 1'b1;
        checks++; if (n !== 8) begin failures++; $display("FAIL stall_beat_count: got %0d want 8", n); end
        checks++; if (stalls !== 3) begin failures++; $display("FAIL stall_cycles: got %0d want 3", stalls); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_missed_and_abort();
        arm_cfg(16'd0, 11'd4);
        fire_trigger();
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 128'h31; tick();
        s_axis_tdata = 128'h32; trigger = 1'b0; tick();
        s_axis_tdata = 128'h33; trigger = 1'b1; tick();
        s_axis_tdata = 128'h34; tick();
        s_axis_tvalid = 1'b0;
        checks++; if (trig_missed !== 1'b1) begin failures++; $display("FAIL missed_flag: got %0b want 1", trig_missed); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL missed_done: got %0b want 1", done); end
        start_readout();
        collect(10, 2);
        checks++; if (got_n !== 2) begin failures++; $display("FAIL missed_beat_count: got %0d want 2", got_n); end
        checks++; if (got[0] !== 128'h31) begin failures++; $display("FAIL missed_beat0: got %0h want 31", got[0]); end
        checks++; if (got[1] !== 128'h32) begin failures++; $display("FAIL missed_beat1: got %0h want 32", got[1]); end
        checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL abort_pre_tvalid: got %0b want 1", m_axis_tvalid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL abort_tvalid: got %0b want 0", m_axis_tvalid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %0b want 0", done); end
        checks++; if (trig_missed !== 1'b0) begin failures++; $display("FAIL abort_clears_missed: got %0b want 0", trig_missed); end
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_over_arm: got %0b want 0", busy); end
    endtask

    task automatic test_zero_len();
        arm_cfg(16'd0, 11'd0);
        fire_trigger();
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_ready: got %0b want 0", busy); end
        start_readout();
        collect(6, 1);
        checks++; if (got_n !== 0) begin failures++; $display("FAIL zero_no_beats: got %0d want 0", got_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_after: got %0b want 0", done); end
    endtask

    task automatic test_clamp();
        arm_cfg(16'd0, 11'd2047);
        fire_trigger();
        feed(128'h5000, 1023);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL clamp_done_early: got %0b want 0", done); end
        feed(128'h5000 + 128'd1023, 1);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL clamp_done: got %0b want 1", done); end
        start_readout();
        collect(1100, 1100);
        checks++; if (got_n !== 1024) begin failures++; $display("FAIL clamp_beat_count: got %0d want 1024", got_n); end
        checks++; if (got[0] !== 128'h5000) begin failures++; $display("FAIL clamp_first: got %0h want 5000", got[0]); end
        checks++; if (got[1023] !== 128'h53FF) begin failures++; $display("FAIL clamp_last: got %0h want 53ff", got[1023]); end
    endtask

`ifdef ADC_CAPTURE_TLAST_EN
    task automatic test_tlast();
        int n;
        arm_cfg(16'd0, 11'd3);
        fire_trigger();
        feed(128'h70, 3);
        start_readout();
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_axis_tvalid) begin
                checks++;
                if (m_axis_tlast !== (n == 2)) begin
                    failures++; $display("FAIL tlast_beat%0d: got %0b want %0b", n, m_axis_tlast, (n == 2));
                end
                n++;
            end
            tick();
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL tlast_beat_count: got %0d want 3", n); end
    endtask
`endif

    task automatic test_reset_midop();
        arm_cfg(16'd0, 11'd8);
        fire_trigger();
        feed(128'h90, 3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %0b want 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid: got %0b want 0", m_axis_tvalid); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %0b want 0", done); end
    endtask

    initial begin
        rst           = 1'b0;
        arm           = 1'b0;
        abort         = 1'b0;
        trigger       = 1'b0;
        capture_delay = '0;
        capture_len   = '0;
        channel_sel   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_basic_capture();
        test_delay();
        test_tvalid_gaps();
        test_stall();
        test_missed_and_abort();
        test_zero_len();
        test_clamp();
`ifdef ADC_CAPTURE_TLAST_EN
        test_tlast();
`endif
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
